// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK command sequencer: op codes and FSM states.
package jk_seq_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command queue for the JK sequencer: circular buffer with occupancy count and
// synchronous flush. Push is refused when full even if a pop happens that cycle.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues {op,cnt} commands and drives registered j,k for cnt+1 cycles each.
// Define JK_SEQ_SHADOW_EN to get a shadow model of downstream q on q_exp.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [CNT_W-1:0]       in_cnt,
  input  logic                   flush,
  output logic                   j,
  output logic                   k,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   q_exp
);
  localparam int CW = 2 + CNT_W;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   rem, rem_nx;
  logic               j_nx, k_nx;
  logic               pop, full, empty, push;
  logic [CW-1:0]      head;

  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign busy     = (state == ST_ISSUE);

  jk_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_op, in_cnt}),
    .pop   (pop),
    .rdata (head),
    .flush (flush),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rem   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      j     <= j_nx;
      k     <= k_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    j_nx     = j;
    k_nx     = k;
    pop      = 1'b0;
    if (flush) begin
      state_nx = ST_IDLE;
      rem_nx   = '0;
      j_nx     = 1'b0;
      k_nx     = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          j_nx = 1'b0;
          k_nx = 1'b0;
          if (!empty) begin
            pop          = 1'b1;
            {j_nx, k_nx} = head[CW-1 -: 2];
            rem_nx       = head[CNT_W-1:0];
            state_nx     = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (rem != '0) begin
            rem_nx = rem - 1'b1;
          end else if (!empty) begin
            // chain straight into the next command, no idle cycle
            pop          = 1'b1;
            {j_nx, k_nx} = head[CW-1 -: 2];
            rem_nx       = head[CNT_W-1:0];
          end else begin
            state_nx = ST_IDLE;
            j_nx     = 1'b0;
            k_nx     = 1'b0;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          j_nx     = 1'b0;
          k_nx     = 1'b0;
        end
      endcase
    end
  end

`ifdef JK_SEQ_SHADOW_EN
  logic q_shadow;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_shadow <= 1'b0;
    end else begin
      case ({j, k})
        OP_RESET:  q_shadow <= 1'b0;
        OP_SET:    q_shadow <= 1'b1;
        OP_TOGGLE: q_shadow <= ~q_shadow;
        default:   q_shadow <= q_shadow;
      endcase
    end
  end
  assign q_exp = q_shadow;
`else
  assign q_exp = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with hand-computed j/k/level/busy/q_exp values.
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_op;
  logic [CNT_W-1:0]       in_cnt;
  logic                   flush;
  logic                   j, k, busy, q_exp;
  logic [$clog2(DEPTH):0] level;

  int n_chk  = 0;
  int n_fail = 0;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_cnt   (in_cnt),
    .flush    (flush),
    .j        (j),
    .k        (k),
    .busy     (busy),
    .level    (level),
    .q_exp    (q_exp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input int cnt);
    in_valid = 1'b1;
    in_op    = op;
    in_cnt   = CNT_W'(cnt);
  endtask

  // Expected q_exp: shadow value when the feature is built in, else 0.
  function automatic int qw(input int v);
`ifdef JK_SEQ_SHADOW_EN
    return v;
`else
    return 0;
`endif
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_cnt = '0; flush = 1'b0;
    #3;
    chk("rst_jk", {j, k}, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", q_exp, 0);
    #9 rst_n = 1'b1;
    tick();
    chk("rel_ready", in_ready, 1);
    chk("rel_busy", busy, 0);

    // single command: set, cnt=2
    drive(2'b10, 2); tick(); in_valid = 1'b0;
    chk("s0_level", level, 1);
    chk("s0_jk", {j, k}, 0);
    tick();
    chk("s1_jk", {j, k}, 2);
    chk("s1_busy", busy, 1);
    chk("s1_level", level, 0);
    chk("s1_q", q_exp, 0);
    tick();
    chk("s2_jk", {j, k}, 2);
    chk("s2_q", q_exp, qw(1));
    tick();
    chk("s3_jk", {j, k}, 2);
    tick();
    chk("s4_jk", {j, k}, 0);
    chk("s4_busy", busy, 0);
    chk("s4_q", q_exp, qw(1));

    // back-to-back: 11/0, 01/1, 10/0
    drive(2'b11, 0); tick();
    chk("b0_level", level, 1);
    drive(2'b01, 1); tick();
    chk("b1_jk", {j, k}, 3);
    chk("b1_level", level, 1);
    drive(2'b10, 0); tick(); in_valid = 1'b0;
    chk("b2_jk", {j, k}, 1);
    chk("b2_level", level, 1);
    chk("b2_q", q_exp, 0);
    tick();
    chk("b3_jk", {j, k}, 1);
    tick();
    chk("b4_jk", {j, k}, 2);
    chk("b4_level", level, 0);
    tick();
    chk("b5_jk", {j, k}, 0);
    chk("b5_busy", busy, 0);
    chk("b5_q", q_exp, qw(1));

    // clear the shadow with a reset op
    drive(2'b01, 0); tick(); in_valid = 1'b0;
    tick();
    chk("c1_jk", {j, k}, 1);
    tick();
    chk("c2_jk", {j, k}, 0);
    chk("c2_q", q_exp, 0);

    // toggle cnt=3: q follows 1,0,1,0 then holds
    drive(2'b11, 3); tick(); in_valid = 1'b0;
    tick();
    chk("t1_jk", {j, k}, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t%0d_q", i + 2), q_exp, qw((i % 2 == 0) ? 1 : 0));
      chk($sformatf("t%0d_jk", i + 2), {j, k}, (i < 3) ? 3 : 0);
    end
    tick();
    chk("t6_q", q_exp, 0);
    chk("t6_busy", busy, 0);

    // full queue behind a max-count command
    drive(2'b10, 15); tick();   // A
    drive(2'b01, 0);  tick();   // B (A popped)
    drive(2'b11, 0);  tick();   // C
    drive(2'b10, 0);  tick();   // D
    drive(2'b01, 0);  tick();   // E
    chk("f_level", level, 4);
    chk("f_ready", in_ready, 0);
    chk("f_jk", {j, k}, 2);
    drive(2'b11, 0);            // F waits for space
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("f_wait", n, 13);
    chk("f_B_jk", {j, k}, 1);
    chk("f_nobypass_level", level, 3);
    tick(); in_valid = 1'b0;
    chk("f_C_jk", {j, k}, 3);
    chk("f_C_level", level, 3);
    tick();
    chk("f_D_jk", {j, k}, 2);
    tick();
    chk("f_E_jk", {j, k}, 1);
    tick();
    chk("f_F_jk", {j, k}, 3);
    chk("f_F_level", level, 0);
    tick();
    chk("f_end_jk", {j, k}, 0);
    chk("f_end_busy", busy, 0);

    // flush mid-issue with level=3 and a push offered
    drive(2'b10, 15); tick();
    drive(2'b01, 0);  tick();
    drive(2'b11, 0);  tick();
    drive(2'b01, 0);  tick();
    chk("x_level", level, 3);
    chk("x_busy", busy, 1);
    drive(2'b11, 0); flush = 1'b1;
    #1;
    chk("x_ready", in_ready, 0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("x_level0", level, 0);
    chk("x_jk", {j, k}, 0);
    chk("x_busy0", busy, 0);
    tick();
    chk("x_idle_level", level, 0);
    chk("x_idle_jk", {j, k}, 0);

    // asynchronous reset mid-issue
    drive(2'b11, 5); tick();
    drive(2'b10, 1); tick(); in_valid = 1'b0;
    tick();
    chk("r_busy", busy, 1);
    chk("r_level", level, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_jk", {j, k}, 0);
    chk("r_level0", level, 0);
    chk("r_busy0", busy, 0);
    chk("r_q", q_exp, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("r_ready", in_ready, 1);
    chk("r_idle", busy, 0);
    chk("r_idle_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command queue entries (power of 2, at least 2).
REQ-002 SHALL have parameter CNT_W, default 4, meaning repeat-count width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: command offered.
REQ-006 SHALL have port in_ready, output, 1 bit: command accepted when in_valid and in_ready are both high at an edge.
REQ-007 SHALL have port in_op, input, 2 bits: op {j,k}, where 00=hold, 01=reset, 10=set, 11=toggle.
REQ-008 SHALL have port in_cnt, input, CNT_W bits: op is driven for in_cnt+1 cycles.
REQ-009 SHALL have port flush, input, 1 bit: discard queue and current command.
REQ-010 SHALL have ports j and k, outputs, 1 bit each: registered drive to the downstream JK flip-flop.
REQ-011 SHALL have port busy, output, 1 bit: state is ISSUE.
REQ-012 SHALL have port level, output, log2(DEPTH)+1 bits: queue occupancy.
REQ-013 SHALL have port q_exp, output, 1 bit: predicted downstream q (see Configuration).

Function
REQ-014 SHALL hold commands in a FIFO; in_ready = !full && !flush, with no push-bypass when full (a pop in the same cycle does not free space).
REQ-015 SHALL implement FSM states IDLE and ISSUE; j=k=0 whenever in IDLE.
REQ-016 IDLE with queue non-empty SHALL pop at the next edge, load j,k from the op, load remaining=cnt, and enter ISSUE.
REQ-017 ISSUE with remaining>0 SHALL decrement remaining and keep j,k.
REQ-018 ISSUE with remaining==0 SHALL pop the next command in the same edge if the queue is non-empty (no bubble); otherwise it SHALL enter IDLE with j=k=0.
REQ-019 A command accepted at edge T into an empty queue while IDLE SHALL appear on j,k after edge T+1 and remain for exactly cnt+1 cycles.
REQ-020 in_cnt at its maximum value (2^CNT_W-1) SHALL give 2^CNT_W cycles, with no wrap to zero.
REQ-021 Simultaneous push and pop when the queue is non-full SHALL leave level unchanged.
REQ-022 flush SHALL have priority over push, pop and decrement; after the flush edge: queue empty, state IDLE, j=k=0, level=0.

Reset
REQ-023 While rst_n is low: state IDLE, queue empty, level=0, j=0, k=0, busy=0, q_exp=0, remaining=0; in_ready SHALL be 1 once rst_n is released.

Configuration
REQ-024 With JK_SEQ_SHADOW_EN defined, q_exp SHALL be a register updated each edge from the current j,k: hold keeps q_exp, 01 clears it, 10 sets it, 11 inverts it. flush SHALL not alter q_exp.
REQ-025 Without JK_SEQ_SHADOW_EN, q_exp SHALL be tied to 0 and no shadow register SHALL exist.

Structure
REQ-026 Package jk_seq_pkg SHALL hold the op encodings (OP_HOLD=00, OP_RESET=01, OP_SET=10, OP_TOGGLE=11) and the FSM state encodings.
REQ-027 The queue SHALL be a sub-module jk_cmd_fifo, parameterised by DEPTH and width 2+CNT_W, with push, pop, flush, full, empty and level.

Verification
REQ-028 Reset check: rst_n low mid-ISSUE -> j=k=0, level=0, busy=0 immediately (asynchronously); in_ready=1 after release.
REQ-029 Single command: push op=10, cnt=2 at edge T -> j=1, k=0 for edges T+1..T+3, then j=k=0, busy=0; with shadow, q_exp=1 from edge T+2.
REQ-030 Back-to-back: push ops 11/cnt=0, 01/cnt=1, 10/cnt=0 -> j,k sequence 11,01,01,10 with no idle gap, then 00.
REQ-031 Full queue: push 5 commands with DEPTH=4 while ISSUE runs cnt=15 -> in_ready=0 at level=4, 5th accepted only after a pop, order preserved.
REQ-032 Flush: flush=1 with level=3 mid-ISSUE, in_valid=1 -> push ignored; next cycle level=0, j=k=0, busy=0.
REQ-033 Toggle shadow: op=11, cnt=3 from q_exp=0 -> q_exp follows 1,0,1,0, then holds 0.
